// File: rtl/shift_normalize_pkg.sv
// Shared types and helpers for the shift_normalize iterative normalizer.
// Holds the FSM state enum, the default data width and the all-bits-equal test.
package norm_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_WIDTH     = 64;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  // True when every bit of vec is identical (all zeros or all ones).
  function automatic logic all_equal(input logic [MAX_WIDTH-1:0] vec);
    return (vec == '0) || (vec == '1);
  endfunction

endpackage

// File: rtl/shift_normalize_if.sv
// Request/result bundle of the shift_normalize block.
// The master drives START/X/SIGNED; the slave (the normalizer) returns Z/S/ZERO/BUSY/DONE.
interface shift_normalize_if #(
  parameter int WIDTH = norm_pkg::DEFAULT_WIDTH
);
  localparam int SW = $clog2(WIDTH);

  logic             START;
  logic [WIDTH-1:0] X;
  logic             SIGNED;
  logic [WIDTH-1:0] Z;
  logic [SW-1:0]    S;
  logic             ZERO;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, X, SIGNED,
    input  Z, S, ZERO, BUSY, DONE
  );

  modport slave (
    input  START, X, SIGNED,
    output Z, S, ZERO, BUSY, DONE
  );

endinterface

// File: rtl/shift_normalize_stage.sv
// One binary-search stage: tests whether the top `step` bits (unsigned) or the
// top step+1 bits (signed) are redundant, and offers the work word shifted by step.
module norm_stage
  import norm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]         work,
  input  logic [$clog2(WIDTH)-1:0] step,
  input  logic                     mode,
  output logic                     pass,
  output logic [WIDTH-1:0]         shifted
);

  logic signed [WIDTH-1:0] window;
  logic        [WIDTH-1:0] top_u;

  always_comb begin
    // Arithmetic shift leaves only the step+1 window plus copies of its sign,
    // so the whole word is uniform exactly when the window is.
    window  = $signed(work) >>> (WIDTH - 1 - int'(step));
    top_u   = work >> (WIDTH - int'(step));
    pass    = mode ? all_equal(MAX_WIDTH'(window)) : (top_u == '0);
    shifted = work << step;
  end

endmodule

// File: rtl/shift_normalize.sv
// Iterative normalizer: derives the left shift that normalizes X (leading-zero or
// redundant-sign count), one binary-search stage per clock. NORM_EARLY_EXIT_EN
// lets already-normalized or zero operands finish one cycle after acceptance.
module shift_normalize
  import norm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  shift_normalize_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic             mode_q,  mode_d;
  logic [SW-1:0]    cnt_q,   cnt_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic             xzero_q, xzero_d;
  logic             skip_q,  skip_d;
  logic [WIDTH-1:0] z_q,     z_d;
  logic [SW-1:0]    s_q,     s_d;
  logic             zero_q,  zero_d;
  logic             done_q,  done_d;

  logic [SW-1:0]    step;
  logic             stage_pass;
  logic [WIDTH-1:0] stage_shifted;
  logic [WIDTH-1:0] next_work;
  logic [SW-1:0]    next_cnt;
  logic             early;

  assign step = SW'(1) << stage_q;

  norm_stage #(.WIDTH(WIDTH)) u_stage (
    .work    (work_q),
    .step    (step),
    .mode    (mode_q),
    .pass    (stage_pass),
    .shifted (stage_shifted)
  );

`ifdef NORM_EARLY_EXIT_EN
  assign early = (bus.X == '0) ||
                 (bus.SIGNED ? (bus.X[WIDTH-1] != bus.X[WIDTH-2]) : bus.X[WIDTH-1]);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps synthesis from inferring latches here.
    state_d   = state_q;
    work_d    = work_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    xzero_d   = xzero_q;
    skip_d    = skip_q;
    z_d       = z_q;
    s_d       = s_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    next_work = stage_pass ? stage_shifted : work_q;
    next_cnt  = stage_pass ? cnt_q + step : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          work_d  = bus.X;
          mode_d  = bus.SIGNED;
          cnt_d   = '0;
          stage_d = SW'(SW - 1);
          xzero_d = (bus.X == '0);
          skip_d  = early;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (skip_q) begin
          // Early exit: operand is already its own normalized form.
          z_d     = work_q;
          s_d     = xzero_q ? SW'(WIDTH - 1) : '0;
          zero_d  = xzero_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          work_d = next_work;
          cnt_d  = next_cnt;
          if (stage_q == '0) begin
            z_d     = next_work;
            s_d     = next_cnt;
            zero_d  = xzero_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stage_d = stage_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      work_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      stage_q <= '0;
      xzero_q <= 1'b0;
      skip_q  <= 1'b0;
      z_q     <= '0;
      s_q     <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      xzero_q <= xzero_d;
      skip_q  <= skip_d;
      z_q     <= z_d;
      s_q     <= s_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign bus.Z    = z_q;
  assign bus.S    = s_q;
  assign bus.ZERO = zero_q;
  assign bus.BUSY = (state_q == BUSY);
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_shift_normalize.sv
// Self-checking bench for shift_normalize: directed corner cases plus random
// operands compared against a bit-counting reference model.
module tb_shift_normalize;

  localparam int W  = 32;
  localparam int SW = $clog2(W);

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic [SW-1:0] last_s;
  logic [W-1:0]  last_z;
  logic          last_zero;

  shift_normalize_if #(.WIDTH(W)) bus ();

  shift_normalize #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: count leading bits directly, then shift.
  task automatic ref_norm(input logic [W-1:0] x, input logic sgn,
                          output logic [SW-1:0] s, output logic [W-1:0] z);
    int n;
    n = 0;
    if (!sgn) begin
      while (n < W && x[W-1-n] == 1'b0) n++;
    end else begin
      while (n < W && x[W-1-n] == x[W-1]) n++;
      n--;
    end
    if (n > W - 1) n = W - 1;
    s = SW'(n);
    z = x << n;
  endtask

  function automatic int exp_latency(input logic [W-1:0] x, input logic sgn);
`ifdef NORM_EARLY_EXIT_EN
    if (x == '0) return 1;
    if (sgn ? (x[W-1] != x[W-2]) : x[W-1]) return 1;
`endif
    return SW;
  endfunction

  // Presents a request; returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic sgn);
    bus.START  = 1'b1;
    bus.X      = x;
    bus.SIGNED = sgn;
    @(posedge clk);
    #1;
    bus.START  = 1'b0;
    bus.X      = $urandom;
    bus.SIGNED = 1'b0;
    check("accept busy", bus.BUSY, 1'b1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.DONE && lat < 50);
    check("done seen", bus.DONE, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic sgn);
    logic [SW-1:0] es;
    logic [W-1:0]  ez;
    int            lat;
    ref_norm(x, sgn, es, ez);
    start_op(x, sgn);
    check({tag, " hold S"}, bus.S, last_s);
    check({tag, " hold Z"}, bus.Z, last_z);
    wait_done(lat);
    check({tag, " latency"}, lat, exp_latency(x, sgn));
    check({tag, " S"}, bus.S, es);
    check({tag, " Z"}, bus.Z, ez);
    check({tag, " ZERO"}, bus.ZERO, (x == '0));
    check({tag, " busy at done"}, bus.BUSY, 1'b0);
    last_s    = es;
    last_z    = ez;
    last_zero = (x == '0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " Z"}, bus.Z, '0);
    check({tag, " S"}, bus.S, '0);
    check({tag, " ZERO"}, bus.ZERO, 1'b0);
    check({tag, " BUSY"}, bus.BUSY, 1'b0);
    check({tag, " DONE"}, bus.DONE, 1'b0);
  endtask

  initial begin
    int            done_cnt;
    logic [SW-1:0] seen_s;
    logic [W-1:0]  seen_z;
    logic [W-1:0]  x;
    logic [W-1:0]  r;
    logic          sgn;
    int            k;

    rst_n      = 1'b0;
    bus.START  = 1'b0;
    bus.X      = '0;
    bus.SIGNED = 1'b0;
    last_s     = '0;
    last_z     = '0;
    last_zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases; consecutive calls also start on the DONE cycle.
    run_op("u one",      32'h0000_0001, 1'b0);
    run_op("s one",      32'h0000_0001, 1'b1);
    run_op("s ones",     32'hFFFF_FFFF, 1'b1);
    run_op("u zero",     32'h0000_0000, 1'b0);
    run_op("s zero",     32'h0000_0000, 1'b1);
    run_op("u f00000",   32'h00F0_0000, 1'b0);
    run_op("s neg",      32'hFFF0_1234, 1'b1);
    run_op("s norm",     32'h4000_0000, 1'b1);

    // START pulsed while busy must be ignored: one DONE, first operand's result.
    start_op(32'h00F0_0000, 1'b0);
    @(posedge clk);
    #1;
    bus.START  = 1'b1;
    bus.X      = 32'h0000_0003;
    bus.SIGNED = 1'b0;
    @(posedge clk);
    #1;
    bus.START  = 1'b0;
    done_cnt = 0;
    seen_s   = '0;
    seen_z   = '0;
    repeat (2 * SW + 4) begin
      @(posedge clk);
      #1;
      if (bus.DONE) begin
        done_cnt++;
        seen_s = bus.S;
        seen_z = bus.Z;
      end
    end
    check("busy start done count", done_cnt, 1);
    check("busy start S", seen_s, 8);
    check("busy start Z", seen_z, 32'hF000_0000);
    last_s = 8;
    last_z = 32'hF000_0000;

    // Reset with stage 2 pending aborts immediately and produces no DONE.
    start_op(32'h0000_0001, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (SW + 3) begin
      @(posedge clk);
      #1;
      if (bus.DONE) done_cnt++;
    end
    check("mid reset no done", done_cnt, 0);
    last_s = '0;
    last_z = '0;
    run_op("u msb", 32'h8000_0000, 1'b0);

    // Random operands with varied leading-bit runs.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, W - 1);
      r   = $urandom;
      case ($urandom_range(0, 3))
        0:       x = r >> k;
        1:       x = W'($signed(r) >>> k);
        2:       x = ~(r >> k);
        default: x = r;
      endcase
      run_op("rand", x, sgn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
